// File: rtl/gate_tt_pkg.sv
// gate_tt_pkg: shared encodings for the 2-input gate truth-table checker.
// Holds gate select codes, FSM states and the vector count.
package gate_tt_pkg;

  typedef enum logic [2:0] {
    GS_AND  = 3'd0,
    GS_OR   = 3'd1,
    GS_NAND = 3'd2,
    GS_NOR  = 3'd3,
    GS_XOR  = 3'd4,
    GS_XNOR = 3'd5,
    GS_BUF  = 3'd6,
    GS_NOT  = 3'd7
  } gate_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int unsigned VEC_COUNT = 4;

endpackage

// File: rtl/gate_tt_ref.sv
// gate_tt_ref: expected output of the selected 2-input gate.
// Ports: sel (gate code), a, b (gate inputs) -> expected.
module gate_tt_ref
  import gate_tt_pkg::*;
(
  input  logic [2:0] sel,
  input  logic       a,
  input  logic       b,
  output logic       expected
);

  always_comb begin
    expected = 1'b0;
    unique case (gate_sel_e'(sel))
      GS_AND:  expected = a & b;
      GS_OR:   expected = a | b;
      GS_NAND: expected = ~(a & b);
      GS_NOR:  expected = ~(a | b);
      GS_XOR:  expected = a ^ b;
      GS_XNOR: expected = ~(a ^ b);
      GS_BUF:  expected = a;
      GS_NOT:  expected = ~a;
    endcase
  end

endmodule

// File: rtl/gate_tt_checker.sv
// gate_tt_checker: sweeps {a,b} through 00..11, holding each DWELL cycles,
// and checks c. Ports: clk, rst, start, gate_sel, c in; a, b, busy, done,
// pass, fail_vec, err_count out (all registered).
module gate_tt_checker
  import gate_tt_pkg::*;
#(
  parameter int unsigned DWELL = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] gate_sel,
  input  logic       c,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [2:0] err_count
);

  localparam int unsigned CW = $clog2(DWELL);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [1:0] VEC_LAST = 2'(VEC_COUNT - 1);
  localparam logic [2:0] ERR_MAX = 3'(VEC_COUNT);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    sel_q, sel_d;
  logic [1:0]    vec_q, vec_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [3:0]    fail_q, fail_d;
  logic [2:0]    err_q, err_d;

  logic          expected;
  logic          mismatch;
  logic [3:0]    fail_upd;
  logic [2:0]    err_upd;

  gate_tt_ref u_ref (
    .sel      (sel_q),
    .a        (vec_q[1]),
    .b        (vec_q[0]),
    .expected (expected)
  );

  assign mismatch = (c != expected);

  // Result as it stands after this vector's compare.
  always_comb begin
    fail_upd = fail_q;
    err_upd  = err_q;
    if (mismatch) begin
      fail_upd = fail_q | (4'b0001 << vec_q);
      if (err_q != ERR_MAX) begin
        err_upd = err_q + 3'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    fail_d  = fail_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_APPLY;
          sel_d   = gate_sel;
          cnt_d   = '0;
          vec_d   = 2'd0;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          fail_d  = 4'd0;
          err_d   = 3'd0;
        end
      end
      ST_APPLY: begin
        if (cnt_q == CNT_LAST) begin
          fail_d = fail_upd;
          err_d  = err_upd;
          cnt_d  = '0;
          if (vec_q == VEC_LAST) begin
            state_d = ST_DONE;
            vec_d   = 2'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_upd == 3'd0);
          end else begin
            vec_d = vec_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= 3'd0;
      vec_q   <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 4'd0;
      err_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
    end
  end

  assign a         = vec_q[1];
  assign b         = vec_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_vec  = fail_q;
  assign err_count = err_q;

endmodule
